arb_rr_4: RTL and testbench
===========================

ARB_RR_4 -- requirements
Module: arb_rr_4

Interface
REQ-001 Parameter MAX_HOLD SHALL be declared: default 8; maximum consecutive cycles one owner keeps the grant while others wait; legal range 1..255.
REQ-002 Port clock SHALL be: input, 1 bit, sole clock; all state updates on its rising edge.
REQ-003 Port reset_b SHALL be: input, 1 bit, reset; synchronous and active-low.
REQ-004 Ports req0, req1, req2, req3 SHALL each be: input, 1 bit, level request from requester 0..3.
REQ-005 Ports g0, g1, g2, g3 SHALL each be: output, 1 bit, registered grant; together they form the one-hot word driving the downstream 4-input encoder's i0..i3.
REQ-006 Port busy SHALL be: output, 1 bit, registered; 1 whenever any grant is asserted.

Function
REQ-007 {g3,g2,g1,g0} SHALL be all-zero or exactly one-hot in every cycle; busy SHALL equal OR of g0..g3.
REQ-008 Internal state: FSM {IDLE, GRANT}, 2-bit priority pointer ptr, 2-bit owner, hold counter hcnt wide enough for MAX_HOLD.
REQ-009 Pick rule: the selected requester SHALL be the first asserted req scanning ptr, ptr+1, ... modulo 4, with an optional excluded index.
REQ-010 IDLE, no req asserted: SHALL stay IDLE, grants 0000.
REQ-011 IDLE, any req asserted at edge N: SHALL enter GRANT with the picked index as owner and its grant asserted after edge N (one-cycle latency); hcnt=1.
REQ-012 GRANT, req[owner]=1 and (hcnt<MAX_HOLD or no other req asserted): SHALL keep the grant; hcnt increments, saturating at MAX_HOLD.
REQ-013 GRANT, req[owner]=0: ptr SHALL become owner+1 mod 4; if another req is asserted, the grant SHALL move to the pick (from owner+1, excluding owner) at the same edge with no idle gap and hcnt=1; otherwise grants SHALL go to 0000 and the FSM to IDLE.
REQ-014 GRANT, req[owner]=1, hcnt==MAX_HOLD, another req asserted: the grant SHALL be revoked and passed to the pick (from owner+1, excluding owner) at the same edge; ptr=owner+1; hcnt=1.
REQ-015 The revoked owner SHALL re-enter arbitration normally and SHALL NOT be granted again before every other requester asserted at the handover has been served once.
REQ-016 Simultaneous release by the owner and new requests: the new requests SHALL be honoured under REQ-013 in the same cycle.
REQ-017 Request pulses shorter than one cycle and not sampled at an edge SHALL be ignored.

Reset
REQ-018 While reset_b=0 at a rising edge: FSM=IDLE, ptr=0, owner=0, hcnt=0, g0..g3=0, busy=0.
REQ-019 Reset asserted mid-grant SHALL drop all grants at that edge; the first post-reset arbitration SHALL start from ptr=0.

Structure
REQ-020 Shared package arb_pkg SHALL hold the FSM state encodings and DEFAULT_MAX_HOLD=8; nothing else.
REQ-021 Combinational sub-module rr_pick4 SHALL implement REQ-009 (inputs req[3:0], ptr, exclude-enable, exclude index; outputs found, index); arb_rr_4 SHALL instantiate it once.
REQ-022 All outputs SHALL be driven directly from flops; there SHALL be no combinational path from req to g.

Verification
REQ-023 Reset then req=0001 held -> g=0001 from the next edge, busy=1, held indefinitely (no other requesters).
REQ-024 From reset, req=1111 at one edge -> g=0001; drop req0 -> g=0010 at the next edge, no 0000 gap; then 0100, 1000 in turn.
REQ-025 MAX_HOLD=8, req0 held, req2 raised at grant cycle 3 -> g=0001 for exactly 8 cycles, then g=0100; req0 still held -> g=0001 after req2 releases.
REQ-026 Owner g=0010, req1 drops in the same cycle req3 and req0 rise -> next g=1000 (ptr=2 scan finds 3 before 0).
REQ-027 reset_b=0 while g=0100 -> g=0000, busy=0 at that edge; after release with req=0110 -> g=0010.
REQ-028 Every cycle of every test: grant word is 0000 or one-hot, busy matches, grant never asserted for a req that was 0 at the previous edge.

Source files
------------

// File: rtl/arb_pkg.sv
// ----------------------------------------------------------------------------
// arb_pkg
//
// Purpose:
//    Shared definitions for the four-way round-robin arbiter: the encoding of
//    the arbiter state machine and the default grant hold limit.
//
// Ports:
//    none (package)
// ----------------------------------------------------------------------------
package arb_pkg;

    // IDLE means no grant is outstanding; GRANT means exactly one owner holds
    // the grant.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Longest run of consecutive cycles one owner may keep the grant while
    // somebody else is waiting.
    localparam int DEFAULT_MAX_HOLD = 8;

endpackage : arb_pkg

// File: rtl/rr_pick4.sv
// ----------------------------------------------------------------------------
// rr_pick4
//
// Purpose:
//    Purely combinational round-robin selector for four requesters. Scans the
//    request vector starting at ptr_i and wrapping modulo 4, and returns the
//    first asserted request. One index may be masked out of the scan, which
//    the arbiter uses to skip the current owner when handing the grant over.
//
// Ports:
//    req_i       [3:0]  request vector, bit n belongs to requester n
//    ptr_i       [1:0]  index where the scan starts (highest priority)
//    excl_en_i          when 1, excl_idx_i is never selected
//    excl_idx_i  [1:0]  index to skip while excl_en_i is 1
//    found_o            1 when some eligible request was found
//    index_o     [1:0]  selected requester, meaningful only when found_o=1
// ----------------------------------------------------------------------------
module rr_pick4 (
    input  logic [3:0] req_i,
    input  logic [1:0] ptr_i,
    input  logic       excl_en_i,
    input  logic [1:0] excl_idx_i,
    output logic       found_o,
    output logic [1:0] index_o
);

    logic [1:0] candIdx;

    // Walk the four positions in priority order, starting at ptr_i. The
    // two-bit addition wraps naturally, which gives the modulo-4 rotation.
    // The first eligible hit wins; later hits are ignored because found_o is
    // already set. When nothing is found index_o simply echoes ptr_i so the
    // output is never left undriven.
    always_comb begin
        found_o = 1'b0;
        index_o = ptr_i;
        candIdx = ptr_i;
        for (int k = 0; k < 4; k++) begin
            candIdx = ptr_i + 2'(k);
            if (!found_o && req_i[candIdx] &&
                !(excl_en_i && (candIdx == excl_idx_i))) begin
                found_o = 1'b1;
                index_o = candIdx;
            end
        end
    end

endmodule : rr_pick4

// File: rtl/arb_rr_4.sv
// ----------------------------------------------------------------------------
// arb_rr_4
//
// Purpose:
//    Four-requester round-robin arbiter with a bounded hold time. A granted
//    requester keeps the grant while it keeps requesting, but once it has held
//    it for MAX_HOLD consecutive cycles and somebody else is waiting the grant
//    is taken away and passed on at the same edge. Releasing the request also
//    passes the grant on with no idle cycle in between. All outputs come
//    straight from flops, so there is no combinational path from req to g.
//
// Parameters:
//    MAX_HOLD           consecutive cycles one owner may hold while others
//                       wait (1..255)
//
// Ports:
//    clock              sole clock, rising edge
//    reset_b            synchronous active-low reset
//    req0..req3         level requests from requesters 0..3
//    g0..g3             registered one-hot (or all-zero) grant word
//    busy               registered, 1 whenever any grant is asserted
// ----------------------------------------------------------------------------
module arb_rr_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic clock,
    input  logic reset_b,
    input  logic req0,
    input  logic req1,
    input  logic req2,
    input  logic req3,
    output logic g0,
    output logic g1,
    output logic g2,
    output logic g3,
    output logic busy
);

    // The hold counter must be able to reach MAX_HOLD itself, hence the +1.
    localparam int HCNT_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HCNT_W-1:0] HOLD_LIMIT = HCNT_W'(MAX_HOLD);
    localparam logic [HCNT_W-1:0] HOLD_ONE   = HCNT_W'(1);

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic [1:0]        ptr_q;
    logic [1:0]        ptr_d;
    logic [1:0]        owner_q;
    logic [1:0]        owner_d;
    logic [HCNT_W-1:0] hcnt_q;
    logic [HCNT_W-1:0] hcnt_d;
    logic [3:0]        grant_q;
    logic [3:0]        grant_d;
    logic              busy_q;
    logic              busy_d;

    logic [3:0]        reqVec;
    logic [3:0]        ownerMask;
    logic              ownerReq;
    logic              othersReq;
    logic              holdExpired;
    logic [1:0]        pickPtr;
    logic              pickExclEn;
    logic              pickFound;
    logic [1:0]        pickIndex;

    assign reqVec      = {req3, req2, req1, req0};
    assign ownerMask   = 4'b0001 << owner_q;
    assign ownerReq    = reqVec[owner_q];
    assign othersReq   = |(reqVec & ~ownerMask);
    assign holdExpired = (hcnt_q >= HOLD_LIMIT);

    // From IDLE the scan starts at the stored pointer and nobody is excluded.
    // While a grant is held the only reason to pick is a handover, which
    // always scans from the slot after the owner and skips the owner, so a
    // revoked owner cannot win its own handover.
    assign pickPtr    = (state_q == GRANT) ? (owner_q + 2'd1) : ptr_q;
    assign pickExclEn = (state_q == GRANT);

    rr_pick4 u_pick (
        .req_i      (reqVec),
        .ptr_i      (pickPtr),
        .excl_en_i  (pickExclEn),
        .excl_idx_i (owner_q),
        .found_o    (pickFound),
        .index_o    (pickIndex)
    );

    // Next-state decision for the arbiter.
    //
    // IDLE: any request starts a grant for the picked requester; the pointer
    // is left alone so the first arbitration after reset starts at 0.
    //
    // GRANT: the owner keeps the grant while it requests and either still has
    // hold budget or has nobody competing; the counter saturates at the limit
    // so an uncontested owner can hold indefinitely. Otherwise (release or
    // expired hold with a competitor) the pointer moves past the owner. When
    // there is a competitor the grant moves there at this very edge, giving
    // back-to-back grants without a gap; with no competitor the arbiter goes
    // idle.
    //
    // The registered grant word and busy flag are derived from the next state
    // so they appear one edge after the deciding request sample.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        hcnt_d  = hcnt_q;

        case (state_q)
            IDLE: begin
                if (pickFound) begin
                    state_d = GRANT;
                    owner_d = pickIndex;
                    hcnt_d  = HOLD_ONE;
                end
            end
            GRANT: begin
                if (ownerReq && (!holdExpired || !othersReq)) begin
                    if (!holdExpired) begin
                        hcnt_d = hcnt_q + HOLD_ONE;
                    end
                end else begin
                    ptr_d = owner_q + 2'd1;
                    if (pickFound) begin
                        owner_d = pickIndex;
                        hcnt_d  = HOLD_ONE;
                    end else begin
                        state_d = IDLE;
                        hcnt_d  = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                hcnt_d  = '0;
            end
        endcase

        grant_d = (state_d == GRANT) ? (4'b0001 << owner_d) : 4'b0000;
        busy_d  = (state_d == GRANT);
    end

    // State machine and output registers. Reset is sampled on the clock edge
    // and clears everything, including any grant in flight, so a reset in the
    // middle of a grant drops the outputs at that same edge.
    always_ff @(posedge clock) begin
        if (!reset_b) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            owner_q <= 2'd0;
            hcnt_q  <= '0;
            grant_q <= 4'b0000;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            hcnt_q  <= hcnt_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
        end
    end

    assign g0   = grant_q[0];
    assign g1   = grant_q[1];
    assign g2   = grant_q[2];
    assign g3   = grant_q[3];
    assign busy = busy_q;

endmodule : arb_rr_4

// File: tb/tb_arb_rr_4.sv
// ----------------------------------------------------------------------------
// tb_arb_rr_4
//
// Purpose:
//    Self-checking bench for arb_rr_4. A behavioural model tracks who should
//    own the grant using plain integers, and every cycle the DUT grant word,
//    busy flag, one-hot property and grant-implies-request property are
//    compared against it. Directed scenarios cover the documented cases and
//    a random phase adds a starvation bound check.
// ----------------------------------------------------------------------------
module tb_arb_rr_4;

    localparam int MAXH        = 8;
    localparam int WAIT_BOUND  = 3 * MAXH + 4;
    localparam int RAND_CYCLES = 600;

    logic clock = 1'b0;
    logic reset_b = 1'b0;
    logic req0 = 1'b0;
    logic req1 = 1'b0;
    logic req2 = 1'b0;
    logic req3 = 1'b0;
    logic g0;
    logic g1;
    logic g2;
    logic g3;
    logic busy;

    int total = 0;
    int bad = 0;

    // Model state: is a grant outstanding, who owns it, how long it has been
    // held, and where the next scan from idle begins.
    bit   mActive = 1'b0;
    int   mOwner = 0;
    int   mHold = 0;
    int   mPtr = 0;
    logic [3:0] expG = 4'b0000;
    int   waitCnt [4];

    arb_rr_4 #(.MAX_HOLD(MAXH)) dut (
        .clock   (clock),
        .reset_b (reset_b),
        .req0    (req0),
        .req1    (req1),
        .req2    (req2),
        .req3    (req3),
        .g0      (g0),
        .g1      (g1),
        .g2      (g2),
        .g3      (g3),
        .busy    (busy)
    );

    // Free-running clock, 10 time units per period.
    always #5 clock = ~clock;

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // First asserted request scanning start, start+1, ... mod 4, never
    // returning skip; -1 when there is none.
    function automatic int pickFrom(input logic [3:0] r, input int start, input int skip);
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (start + k) % 4;
            if (r[c] && c != skip) return c;
        end
        return -1;
    endfunction

    // Advance the model by one rising edge with the sampled inputs.
    task automatic modelStep(input logic [3:0] r, input logic rb);
        int w;
        bit others;
        if (!rb) begin
            mActive = 1'b0;
            mOwner  = 0;
            mHold   = 0;
            mPtr    = 0;
        end else if (!mActive) begin
            w = pickFrom(r, mPtr, -1);
            if (w >= 0) begin
                mActive = 1'b1;
                mOwner  = w;
                mHold   = 1;
            end
        end else begin
            others = (pickFrom(r, 0, mOwner) >= 0);
            if (r[mOwner] && (mHold < MAXH || !others)) begin
                if (mHold < MAXH) mHold++;
            end else begin
                mPtr = (mOwner + 1) % 4;
                if (others) begin
                    mOwner = pickFrom(r, mPtr, mOwner);
                    mHold  = 1;
                end else begin
                    mActive = 1'b0;
                end
            end
        end
        expG = mActive ? 4'(1 << mOwner) : 4'b0000;
    endtask

    // Per-cycle comparison of the DUT outputs against the model plus the
    // structural properties of the grant word.
    task automatic checkOutput(input string tag, input logic [3:0] rEdge);
        logic [3:0] gw;
        gw = {g3, g2, g1, g0};
        total++;
        assert (gw === expG) else begin
            bad++;
            $error("[TB] FAIL %s_grant obs=%b exp=%b", tag, gw, expG);
        end
        total++;
        assert (busy === (expG != 4'b0000)) else begin
            bad++;
            $error("[TB] FAIL %s_busy obs=%b exp=%b", tag, busy, (expG != 4'b0000));
        end
        total++;
        assert (($countones(gw) <= 1) && (busy === (gw != 4'b0000))) else begin
            bad++;
            $error("[TB] FAIL %s_onehot obs=%b/%b exp=onehot_or_zero", tag, gw, busy);
        end
        total++;
        assert ((gw & ~rEdge) === 4'b0000) else begin
            bad++;
            $error("[TB] FAIL %s_unrequested obs=%b exp_subset_of=%b", tag, gw, rEdge);
        end
    endtask

    // Directed value comparison against a bench-chosen constant.
    task automatic checkValue(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs away from the edge, let the edge happen, then
    // update the model and compare shortly after.
    task automatic applyStimulus(input logic [3:0] r, input logic rb, input string tag);
        logic [3:0] gw;
        @(negedge clock);
        {req3, req2, req1, req0} = r;
        reset_b = rb;
        @(posedge clock);
        modelStep(r, rb);
        #1;
        checkOutput(tag, r);
        gw = {g3, g2, g1, g0};
        for (int i = 0; i < 4; i++) begin
            if (!rb || !r[i] || gw[i]) waitCnt[i] = 0;
            else waitCnt[i]++;
        end
    endtask

    // A request pulse that lives entirely between two edges must be ignored.
    task automatic glitchStep(input string tag);
        @(negedge clock);
        {req3, req2, req1, req0} = 4'b0000;
        reset_b = 1'b1;
        #1 req3 = 1'b1;
        #1 req3 = 1'b0;
        @(posedge clock);
        modelStep(4'b0000, 1'b1);
        #1;
        checkOutput(tag, 4'b0000);
    endtask

    function automatic int gWord();
        return int'({g3, g2, g1, g0});
    endfunction

    initial begin
        int holdCycles;
        logic [3:0] cur;
        logic rb;
        int worst;

        for (int i = 0; i < 4; i++) waitCnt[i] = 0;

        // Reset state.
        applyStimulus(4'b0000, 1'b0, "reset");
        applyStimulus(4'b0000, 1'b0, "reset");
        checkValue("reset_g", gWord(), 0);
        checkValue("reset_busy", int'(busy), 0);

        // Sub-cycle pulse is ignored.
        glitchStep("glitch");
        checkValue("glitch_g", gWord(), 0);

        // Single requester held indefinitely.
        applyStimulus(4'b0001, 1'b1, "single");
        checkValue("single_first_g", gWord(), 1);
        checkValue("single_first_busy", int'(busy), 1);
        for (int n = 0; n < 15; n++) applyStimulus(4'b0001, 1'b1, "single");
        checkValue("single_held_g", gWord(), 1);

        // All four request, then drop one by one: no gaps.
        applyStimulus(4'b0000, 1'b0, "rst24");
        applyStimulus(4'b1111, 1'b1, "all4");
        checkValue("all4_g0", gWord(), 4'b0001);
        applyStimulus(4'b1110, 1'b1, "all4");
        checkValue("all4_g1", gWord(), 4'b0010);
        applyStimulus(4'b1100, 1'b1, "all4");
        checkValue("all4_g2", gWord(), 4'b0100);
        applyStimulus(4'b1000, 1'b1, "all4");
        checkValue("all4_g3", gWord(), 4'b1000);
        applyStimulus(4'b0000, 1'b1, "all4");
        checkValue("all4_idle", gWord(), 0);

        // Hold limit: req0 held, req2 raised at grant cycle 3.
        applyStimulus(4'b0000, 1'b0, "rst25");
        holdCycles = 0;
        applyStimulus(4'b0001, 1'b1, "hold");
        if (gWord() == 1) holdCycles++;
        applyStimulus(4'b0001, 1'b1, "hold");
        if (gWord() == 1) holdCycles++;
        for (int n = 0; n < 20; n++) begin
            applyStimulus(4'b0101, 1'b1, "hold");
            if (gWord() != 1) break;
            holdCycles++;
        end
        checkValue("hold_cycles", holdCycles, MAXH);
        checkValue("hold_handover_g", gWord(), 4'b0100);
        applyStimulus(4'b0101, 1'b1, "hold");
        applyStimulus(4'b0101, 1'b1, "hold");
        checkValue("hold_req2_kept", gWord(), 4'b0100);
        applyStimulus(4'b0001, 1'b1, "hold");
        checkValue("hold_back_g0", gWord(), 4'b0001);

        // Release by owner 1 while 3 and 0 arrive: scan from 2 finds 3.
        applyStimulus(4'b0000, 1'b0, "rst26");
        applyStimulus(4'b0010, 1'b1, "swap");
        checkValue("swap_owner1", gWord(), 4'b0010);
        applyStimulus(4'b1001, 1'b1, "swap");
        checkValue("swap_g3", gWord(), 4'b1000);

        // Reset mid-grant, then arbitration restarts from pointer 0.
        applyStimulus(4'b0000, 1'b0, "rst27");
        applyStimulus(4'b0100, 1'b1, "midrst");
        checkValue("midrst_g2", gWord(), 4'b0100);
        applyStimulus(4'b0100, 1'b0, "midrst");
        checkValue("midrst_g", gWord(), 0);
        checkValue("midrst_busy", int'(busy), 0);
        applyStimulus(4'b0110, 1'b1, "midrst");
        checkValue("midrst_after_g1", gWord(), 4'b0010);

        // Random phase with occasional resets and a starvation bound.
        applyStimulus(4'b0000, 1'b0, "rstrand");
        cur = 4'b0000;
        for (int n = 0; n < RAND_CYCLES; n++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0) cur[i] = ~cur[i];
            end
            rb = ($urandom_range(0, 63) != 0);
            applyStimulus(cur, rb, "rand");
            worst = 0;
            for (int i = 0; i < 4; i++) if (waitCnt[i] > worst) worst = waitCnt[i];
            total++;
            assert (worst <= WAIT_BOUND) else begin
                bad++;
                $error("[TB] FAIL rand_starve obs=%0d exp_max=%0d", worst, WAIT_BOUND);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_arb_rr_4
